// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 key-schedule types, constants and word functions
package aes_pkg;

    localparam int NUM_ROUNDS = 10;
    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Round constant for round i (1..10); zero outside that range.
    function automatic logic [7:0] rcon(input logic [3:0] i);
        logic [7:0] rc;
        case (i)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // One-byte left rotation: {b0,b1,b2,b3} -> {b1,b2,b3,b0}.
    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    // Forward expansion step. sub is SubWord(RotWord(w3)) of the current key.
    function automatic logic [127:0] fwd_step(input logic [127:0] k, input word_t sub,
                                              input logic [7:0] rc);
        word_t n0, n1, n2, n3;
        n0 = k[127:96] ^ sub ^ {rc, 24'h0};
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Inverse expansion step. sub is SubWord(RotWord(w3 ^ w2)) of the current key,
    // i.e. the S-box of the previous key's last word.
    function automatic logic [127:0] inv_step(input logic [127:0] k, input word_t sub,
                                              input logic [7:0] rc);
        word_t p0, p1, p2, p3;
        p3 = k[31:0] ^ k[63:32];
        p2 = k[63:32] ^ k[95:64];
        p1 = k[95:64] ^ k[127:96];
        p0 = k[127:96] ^ sub ^ {rc, 24'h0};
        return {p0, p1, p2, p3};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational 8-bit AES forward S-box
module aes_sbox (
    input  logic [7:0] data,
    output logic [7:0] subst
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign subst = SBOX[data];

endmodule

// File: rtl/aes_inv_key_sched.sv
// rtl/aes_inv_key_sched.sv - AES-128 decryption round-key generator, keys 10 down to 0
module aes_inv_key_sched
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key,
    output logic         busy,
    output logic [127:0] rk,
    output logic [3:0]   rk_idx,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         done
);

    state_t       state, state_nxt;
    logic [127:0] kreg, kreg_nxt;
    logic [3:0]   cnt, cnt_nxt;
    logic         done_r, done_nxt;

    word_t        sbox_sel;
    word_t        sbox_rot;
    word_t        sub;
    logic [3:0]   cnt_inc;
    logic [3:0]   cnt_dec;

    // Shared S-box input: w3 going forward, w3 ^ w2 (previous key's w3) going back.
    assign sbox_sel = (state == ST_OUT) ? (kreg[31:0] ^ kreg[63:32]) : kreg[31:0];
    assign sbox_rot = rot_word(sbox_sel);

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .data  (sbox_rot[8*b +: 8]),
            .subst (sub[8*b +: 8])
        );
    end

    assign cnt_inc = cnt + 4'd1;
    assign cnt_dec = cnt - 4'd1;

    // Next-state, key-register and counter update for IDLE / FWD / OUT.
    always_comb begin
        state_nxt = state;
        kreg_nxt  = kreg;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    kreg_nxt  = key;
                    cnt_nxt   = 4'd0;
                    state_nxt = ST_FWD;
                end
            end
            ST_FWD: begin
                cnt_nxt  = cnt_inc;
                kreg_nxt = fwd_step(kreg, sub, rcon(cnt_inc));
                if (cnt_inc == LAST_ROUND) begin
                    state_nxt = ST_OUT;
                end
            end
            ST_OUT: begin
                if (rk_ready) begin
                    if (cnt != 4'd0) begin
                        kreg_nxt = inv_step(kreg, sub, rcon(cnt));
                        cnt_nxt  = cnt_dec;
                    end else begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, key, counter and done-pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            kreg   <= '0;
            cnt    <= '0;
            done_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            kreg   <= kreg_nxt;
            cnt    <= cnt_nxt;
            done_r <= done_nxt;
        end
    end

    // Outputs are zero outside OUT so intermediate forward keys never show on the stream.
    assign busy     = (state != ST_IDLE);
    assign rk_valid = (state == ST_OUT);
    assign rk       = rk_valid ? kreg : '0;
    assign rk_idx   = rk_valid ? cnt : '0;
    assign done     = done_r;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// tb/tb_aes_inv_key_sched.sv - directed self-checking bench for aes_inv_key_sched
module tb_aes_inv_key_sched;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] key = '0;
    logic         busy;
    logic [127:0] rk;
    logic [3:0]   rk_idx;
    logic         rk_valid;
    logic         rk_ready = 1'b0;
    logic         done;

    int errors = 0;
    int checks = 0;

    logic [127:0] fips_rk [0:10];
    logic [127:0] zero_rk [0:10];

    aes_inv_key_sched dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .key      (key),
        .busy     (busy),
        .rk       (rk),
        .rk_idx   (rk_idx),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic do_start(input logic [127:0] k);
        @(negedge clk);
        start = 1'b1;
        key   = k;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!rk_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (rk_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", rk_valid); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (rk !== 128'h0) begin errors++; $display("FAIL reset_rk got=%h exp=0", rk); end
        checks++; if (rk_idx !== 4'h0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", rk_idx); end
        rst_n = 1'b1;
    endtask

    task automatic test_fips();
        int lat;
        rk_ready = 1'b1;
        do_start(fips_rk[0]);
        wait_valid(lat);
        checks++; if (lat != 10) begin errors++; $display("FAIL fips_latency got=%0d exp=10", lat); end
        for (int i = 10; i >= 0; i--) begin
            checks++;
            if (rk_valid !== 1'b1 || rk_idx !== 4'(i) || rk !== fips_rk[i]) begin
                errors++;
                $display("FAIL fips_key valid=%b idx=%0d rk=%h exp_idx=%0d exp_rk=%h", rk_valid, rk_idx, rk, i, fips_rk[i]);
            end
            @(negedge clk);
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL fips_done got=%b exp=1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fips_busy_drop got=%b exp=0", busy); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL fips_done_pulse got=%b exp=0", done); end
        checks++; if (rk_valid !== 1'b0) begin errors++; $display("FAIL fips_idle_valid got=%b exp=0", rk_valid); end
    endtask

    task automatic test_backpressure();
        int exp_idx;
        int n;
        int hs;
        logic rdy;
        logic prev_hold;
        logic [127:0] prev_rk;
        logic [3:0] prev_idx;
        exp_idx = 10; n = 0; hs = 0; prev_hold = 1'b0; prev_rk = '0; prev_idx = '0;
        rk_ready = 1'b0;
        do_start(fips_rk[0]);
        while (exp_idx >= 0 && n < 300) begin
            if (prev_hold) begin
                checks++;
                if (rk_valid !== 1'b1 || rk !== prev_rk || rk_idx !== prev_idx) begin
                    errors++;
                    $display("FAIL bp_stall_stable valid=%b idx=%0d rk=%h exp_idx=%0d exp_rk=%h", rk_valid, rk_idx, rk, prev_idx, prev_rk);
                end
            end
            rdy = (n % 3 == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            rk_ready = rdy;
            if (rk_valid && rdy) begin
                checks++;
                if (rk_idx !== 4'(exp_idx) || rk !== fips_rk[exp_idx]) begin
                    errors++;
                    $display("FAIL bp_key idx=%0d rk=%h exp_idx=%0d exp_rk=%h", rk_idx, rk, exp_idx, fips_rk[exp_idx]);
                end
                exp_idx--;
                hs++;
            end
            prev_hold = rk_valid && !rdy;
            prev_rk   = rk;
            prev_idx  = rk_idx;
            @(negedge clk);
            n++;
        end
        checks++; if (hs != 11) begin errors++; $display("FAIL bp_count got=%0d exp=11", hs); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done got=%b exp=1", done); end
        rk_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_start_busy();
        int lat;
        rk_ready = 1'b0;
        do_start(fips_rk[0]);
        repeat (3) @(negedge clk);
        start = 1'b1; key = zero_rk[0];
        @(negedge clk);
        start = 1'b0;
        wait_valid(lat);
        checks++; if (lat != 6) begin errors++; $display("FAIL sb_fwd_latency got=%0d exp=6", lat); end
        start = 1'b1; key = zero_rk[0];
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (rk_valid !== 1'b1 || rk_idx !== 4'd10 || rk !== fips_rk[10]) begin
            errors++;
            $display("FAIL sb_out_hold valid=%b idx=%0d rk=%h exp_rk=%h", rk_valid, rk_idx, rk, fips_rk[10]);
        end
        rk_ready = 1'b1;
        for (int i = 10; i >= 0; i--) begin
            checks++;
            if (rk_valid !== 1'b1 || rk_idx !== 4'(i) || rk !== fips_rk[i]) begin
                errors++;
                $display("FAIL sb_key valid=%b idx=%0d rk=%h exp_idx=%0d exp_rk=%h", rk_valid, rk_idx, rk, i, fips_rk[i]);
            end
            @(negedge clk);
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL sb_done got=%b exp=1", done); end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        int lat;
        int n;
        logic seen;
        rk_ready = 1'b1;
        do_start(fips_rk[0]);
        wait_valid(lat);
        n = 0;
        while (rk_idx != 4'd5 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++; if (rk_idx !== 4'd5) begin errors++; $display("FAIL ar_reach_idx5 got=%0d exp=5", rk_idx); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || rk_valid !== 1'b0 || done !== 1'b0 || rk !== 128'h0 || rk_idx !== 4'h0) begin
            errors++;
            $display("FAIL ar_clear busy=%b valid=%b done=%b rk=%h idx=%0d exp=all zero", busy, rk_valid, done, rk, rk_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (rk_valid || done) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL ar_no_more_keys got=%b exp=0", seen); end
    endtask

    task automatic test_zero_key();
        int lat;
        rk_ready = 1'b1;
        do_start(zero_rk[0]);
        wait_valid(lat);
        checks++; if (lat != 10) begin errors++; $display("FAIL zero_latency got=%0d exp=10", lat); end
        for (int i = 10; i >= 0; i--) begin
            checks++;
            if (rk_valid !== 1'b1 || rk_idx !== 4'(i) || rk !== zero_rk[i]) begin
                errors++;
                $display("FAIL zero_key valid=%b idx=%0d rk=%h exp_idx=%0d exp_rk=%h", rk_valid, rk_idx, rk, i, zero_rk[i]);
            end
            @(negedge clk);
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done got=%b exp=1", done); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat;
        int n;
        rk_ready = 1'b1;
        do_start(fips_rk[0]);
        wait_valid(lat);
        n = 0;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_first_done got=%b exp=1", done); end
        start = 1'b1; key = zero_rk[0];
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got=%b exp=1", busy); end
        wait_valid(lat);
        checks++; if (lat != 10) begin errors++; $display("FAIL b2b_latency got=%0d exp=10", lat); end
        checks++;
        if (rk_idx !== 4'd10 || rk !== zero_rk[10]) begin
            errors++;
            $display("FAIL b2b_key10 idx=%0d rk=%h exp_rk=%h", rk_idx, rk, zero_rk[10]);
        end
        n = 0;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_second_done got=%b exp=1", done); end
        @(negedge clk);
    endtask

    initial begin
        fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        zero_rk[0]  = 128'h00000000000000000000000000000000;
        zero_rk[1]  = 128'h62636363626363636263636362636363;
        zero_rk[2]  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
        zero_rk[3]  = 128'h90973450696ccffaf2f457330b0fac99;
        zero_rk[4]  = 128'hee06da7b876a1581759e42b27e91ee2b;
        zero_rk[5]  = 128'h7f2e2b88f8443e098dda7cbbf34b9290;
        zero_rk[6]  = 128'hec614b851425758c99ff09376ab49ba7;
        zero_rk[7]  = 128'h217517873550620bacaf6b3cc61bf09b;
        zero_rk[8]  = 128'h0ef903333ba9613897060a04511dfa9f;
        zero_rk[9]  = 128'hb1d4d8e28a7db9da1d7bb3de4c664941;
        zero_rk[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

        test_reset();
        test_fips();
        test_backpressure();
        test_start_busy();
        test_async_reset();
        test_zero_key();
        test_back_to_back();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
